// File: rtl/pc_pkg.sv
// pc_pkg: shared types and defaults for the program-counter generator.
package pc_pkg;

   localparam int unsigned PC_DEF_XLEN = 32;
   localparam logic [31:0] PC_DEF_RESET_VECTOR = 32'h0000_0000;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } pc_state_e;

   // Plain-vector views of the states for the legacy-style state register.
   localparam logic [1:0] ST_BOOT = 2'(BOOT);
   localparam logic [1:0] ST_RUN  = 2'(RUN);
   localparam logic [1:0] ST_HALT = 2'(HALT);

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: instruction-fetch request port (valid/ready plus address).
interface pc_gen_if #(
   parameter int unsigned XLEN = 32
);
   logic            o_fetch_valid;
   logic            i_fetch_ready;
   logic [XLEN-1:0] o_pc;
   logic [XLEN-1:0] o_pc_plus;

   modport master (
      output o_fetch_valid,
      output o_pc,
      output o_pc_plus,
      input  i_fetch_ready
   );

   modport slave (
      input  o_fetch_valid,
      input  o_pc,
      input  o_pc_plus,
      output i_fetch_ready
   );
endinterface

// File: rtl/pc_next_sel.sv
// pc_next_sel: combinational priority mux choosing next PC and next state.
module pc_next_sel
   import pc_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [1:0]      state_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] pc_plus_i,
   input  logic            trap_valid_i,
   input  logic [XLEN-1:0] trap_vec_i,
   input  logic            redirect_valid_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   input  logic            redirect_misalign_i,
   input  logic            halt_req_i,
   input  logic            resume_i,
   input  logic            stall_i,
   input  logic            fetch_ready_i,
   output logic [XLEN-1:0] next_pc_c_o,
   output logic [1:0]      next_state_c_o,
   output logic            load_c_o
);

   // Next PC / state selection; trap outranks redirect outranks halt outranks hold.
   always_comb begin
      next_pc_c_o    = pc_i;
      next_state_c_o = state_i;
      load_c_o       = 1'b0;
      case (state_i)
         ST_BOOT: begin
            next_state_c_o = halt_req_i ? ST_HALT : ST_RUN;
         end
         ST_RUN: begin
            if (trap_valid_i) begin
               next_pc_c_o = trap_vec_i;
               load_c_o    = 1'b1;
            end else if (redirect_valid_i) begin
               if (!redirect_misalign_i) begin
                  next_pc_c_o = redirect_pc_i;
                  load_c_o    = 1'b1;
               end
            end else if (halt_req_i) begin
               next_state_c_o = ST_HALT;
            end else if (!stall_i && fetch_ready_i) begin
               next_pc_c_o = pc_plus_i;
            end
         end
         ST_HALT: begin
            if (trap_valid_i) begin
               next_pc_c_o    = trap_vec_i;
               next_state_c_o = ST_RUN;
               load_c_o       = 1'b1;
            end else if (redirect_valid_i) begin
               if (!redirect_misalign_i) begin
                  next_pc_c_o = redirect_pc_i;
                  load_c_o    = 1'b1;
               end
            end else if (resume_i && !halt_req_i) begin
               next_state_c_o = ST_RUN;
            end
         end
         default: begin
            next_state_c_o = ST_BOOT;
         end
      endcase
   end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register with boot/run/halt sequencing and fetch handshake.
// Optional feature: define PC_GEN_ALIGN_CHK_EN to suppress misaligned redirects
// and raise a one-cycle o_misalign pulse.
module pc_gen
   import pc_pkg::*;
#(
   parameter int unsigned     XLEN         = PC_DEF_XLEN,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_DEF_RESET_VECTOR),
   parameter int unsigned     ILEN_BYTES   = 4
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_stall,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   input  logic            i_trap_valid,
   input  logic [XLEN-1:0] i_trap_vec,
   input  logic            i_halt_req,
   input  logic            i_resume,
   pc_gen_if.master        fetch,
   output logic            o_first_after_redirect,
`ifdef PC_GEN_ALIGN_CHK_EN
   output logic            o_misalign,
`endif
   output logic            o_halted
);

   logic [1:0]      state_q,  state_d;
   logic [XLEN-1:0] pc_q,     pc_d;
   logic            valid_q,  valid_d;
   logic            first_q,  first_d;
   logic            halted_q, halted_d;
   logic [1:0]      next_state_c;
   logic [XLEN-1:0] next_pc_c;
   logic [XLEN-1:0] pc_plus_c;
   logic            load_c;
   logic            accept_c;
   logic            misalign_c;

   assign pc_plus_c = pc_q + XLEN'(ILEN_BYTES);
   assign accept_c  = valid_q & fetch.i_fetch_ready & ~i_stall;

`ifdef PC_GEN_ALIGN_CHK_EN
   logic misalign_q, misalign_d;
   logic redir_bad_c;

   // Target alignment check against the instruction granule.
   assign redir_bad_c = (ILEN_BYTES == 2) ? i_redirect_pc[0] : (|i_redirect_pc[1:0]);
   assign misalign_c  = redir_bad_c;
   assign misalign_d  = (state_q != ST_BOOT) & i_redirect_valid & ~i_trap_valid & redir_bad_c;
   assign o_misalign  = misalign_q;
`else
   assign misalign_c = 1'b0;
`endif

   pc_next_sel #(
      .XLEN (XLEN)
   ) u_next_sel (
      .state_i             (state_q),
      .pc_i                (pc_q),
      .pc_plus_i           (pc_plus_c),
      .trap_valid_i        (i_trap_valid),
      .trap_vec_i          (i_trap_vec),
      .redirect_valid_i    (i_redirect_valid),
      .redirect_pc_i       (i_redirect_pc),
      .redirect_misalign_i (misalign_c),
      .halt_req_i          (i_halt_req),
      .resume_i            (i_resume),
      .stall_i             (i_stall),
      .fetch_ready_i       (fetch.i_fetch_ready),
      .next_pc_c_o         (next_pc_c),
      .next_state_c_o      (next_state_c),
      .load_c_o            (load_c)
   );

   // Next-state values for all registered outputs.
   always_comb begin
      state_d  = next_state_c;
      pc_d     = next_pc_c;
      valid_d  = (next_state_c == ST_RUN);
      halted_d = (next_state_c == ST_HALT);
      first_d  = first_q;
      if (load_c) begin
         first_d = 1'b1;
      end else if (accept_c) begin
         first_d = 1'b0;
      end
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q  <= ST_BOOT;
         pc_q     <= RESET_VECTOR;
         valid_q  <= 1'b0;
         first_q  <= 1'b1;
         halted_q <= 1'b0;
`ifdef PC_GEN_ALIGN_CHK_EN
         misalign_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         valid_q  <= valid_d;
         first_q  <= first_d;
         halted_q <= halted_d;
`ifdef PC_GEN_ALIGN_CHK_EN
         misalign_q <= misalign_d;
`endif
      end
   end

   assign fetch.o_fetch_valid  = valid_q;
   assign fetch.o_pc           = pc_q;
   assign fetch.o_pc_plus      = pc_plus_c;
   assign o_first_after_redirect = first_q;
   assign o_halted             = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed self-checking bench for pc_gen.
module tb_pc_gen;
   import pc_pkg::*;

   localparam int unsigned XLEN = 32;

   logic            clk;
   logic            rst_n;
   logic            stall;
   logic            redir_v;
   logic [XLEN-1:0] redir_pc;
   logic            trap_v;
   logic [XLEN-1:0] trap_vec;
   logic            halt_req;
   logic            resume;
   logic            first;
   logic            halted;
`ifdef PC_GEN_ALIGN_CHK_EN
   logic            misalign;
`endif

   int tests_run;
   int tests_failed;

   pc_gen_if #(.XLEN(XLEN)) fetch_if ();

   pc_gen #(
      .XLEN         (XLEN),
      .RESET_VECTOR (32'h0000_1000),
      .ILEN_BYTES   (4)
   ) dut (
      .i_clk                  (clk),
      .i_rst                  (rst_n),
      .i_stall                (stall),
      .i_redirect_valid       (redir_v),
      .i_redirect_pc          (redir_pc),
      .i_trap_valid           (trap_v),
      .i_trap_vec             (trap_vec),
      .i_halt_req             (halt_req),
      .i_resume               (resume),
      .fetch                  (fetch_if),
      .o_first_after_redirect (first),
`ifdef PC_GEN_ALIGN_CHK_EN
      .o_misalign             (misalign),
`endif
      .o_halted               (halted)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Checks pc, valid, first-after-redirect and halted together.
   task automatic check_all(input string tag, input logic [31:0] pc, input logic v,
                            input logic f, input logic h);
      check_eq({tag, ".pc"},     64'(fetch_if.o_pc), 64'(pc));
      check_eq({tag, ".valid"},  64'(fetch_if.o_fetch_valid), 64'(v));
      check_eq({tag, ".first"},  64'(first), 64'(f));
      check_eq({tag, ".halted"}, 64'(halted), 64'(h));
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n    = 1'b0;
      stall    = 1'b0;
      redir_v  = 1'b0;
      redir_pc = '0;
      trap_v   = 1'b0;
      trap_vec = '0;
      halt_req = 1'b0;
      resume   = 1'b0;
      fetch_if.i_fetch_ready = 1'b1;

      // Reset values
      step(); step();
      check_all("reset", 32'h1000, 1'b0, 1'b1, 1'b0);
      check_eq("reset.pc_plus", 64'(fetch_if.o_pc_plus), 64'h1004);
`ifdef PC_GEN_ALIGN_CHK_EN
      check_eq("reset.misalign", 64'(misalign), 64'h0);
`endif

      // Boot then sequential fetch
      rst_n = 1'b1;
      step();
      check_all("run0", 32'h1000, 1'b1, 1'b1, 1'b0);
      step();
      check_all("run1", 32'h1004, 1'b1, 1'b0, 1'b0);
      step();
      check_all("run2", 32'h1008, 1'b1, 1'b0, 1'b0);

      // Redirect to 0x20, then back-pressure for 3 cycles
      redir_v = 1'b1; redir_pc = 32'h20;
      step();
      redir_v = 1'b0;
      check_all("redir20", 32'h20, 1'b1, 1'b1, 1'b0);
      fetch_if.i_fetch_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check_all("notready", 32'h20, 1'b1, 1'b1, 1'b0);
      end
      fetch_if.i_fetch_ready = 1'b1;
      step();
      check_all("ready24", 32'h24, 1'b1, 1'b0, 1'b0);

      // Redirect wins over stall
      stall = 1'b1; redir_v = 1'b1; redir_pc = 32'h400;
      step();
      redir_v = 1'b0;
      check_all("stallredir", 32'h400, 1'b1, 1'b1, 1'b0);
      step();
      check_all("stallhold", 32'h400, 1'b1, 1'b1, 1'b0);
      stall = 1'b0;
      step();
      check_all("unstall", 32'h404, 1'b1, 1'b0, 1'b0);

      // Trap beats redirect in the same cycle
      trap_v = 1'b1; trap_vec = 32'h80; redir_v = 1'b1; redir_pc = 32'h400;
      step();
      trap_v = 1'b0; redir_v = 1'b0;
      check_all("trapwins", 32'h80, 1'b1, 1'b1, 1'b0);
      step();
      check_all("trapnext", 32'h84, 1'b1, 1'b0, 1'b0);

      // Halt at 0x30, redirect while halted, resume
      redir_v = 1'b1; redir_pc = 32'h30;
      step();
      redir_v = 1'b0;
      check_all("redir30", 32'h30, 1'b1, 1'b1, 1'b0);
      halt_req = 1'b1;
      step();
      check_all("halt", 32'h30, 1'b0, 1'b0, 1'b1);
      redir_v = 1'b1; redir_pc = 32'h200;
      step();
      redir_v = 1'b0;
      check_all("haltredir", 32'h200, 1'b0, 1'b1, 1'b1);
      halt_req = 1'b0; resume = 1'b1;
      step();
      resume = 1'b0;
      check_all("resume", 32'h200, 1'b1, 1'b1, 1'b0);
      step();
      check_all("resumenext", 32'h204, 1'b1, 1'b0, 1'b0);

      // Resume ignored while halt request still held; trap leaves HALT
      halt_req = 1'b1;
      step();
      check_all("halt2", 32'h204, 1'b0, 1'b0, 1'b1);
      resume = 1'b1;
      step();
      resume = 1'b0;
      check_all("resumeignored", 32'h204, 1'b0, 1'b0, 1'b1);
      halt_req = 1'b0; trap_v = 1'b1; trap_vec = 32'h80;
      step();
      trap_v = 1'b0;
      check_all("halttrap", 32'h80, 1'b1, 1'b1, 1'b0);

      // Wrap at the top of the address space
      redir_v = 1'b1; redir_pc = 32'hFFFF_FFFC;
      step();
      redir_v = 1'b0;
      check_all("top", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
      check_eq("top.pc_plus", 64'(fetch_if.o_pc_plus), 64'h0);
      step();
      check_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef PC_GEN_ALIGN_CHK_EN
      // Misaligned redirect is suppressed and pulses o_misalign
      stall = 1'b1; redir_v = 1'b1; redir_pc = 32'h102;
      step();
      redir_v = 1'b0;
      check_all("misredir", 32'h0, 1'b1, 1'b0, 1'b0);
      check_eq("misalign.pulse", 64'(misalign), 64'h1);
      step();
      stall = 1'b0;
      check_eq("misalign.clear", 64'(misalign), 64'h0);
      check_eq("misalign.pc", 64'(fetch_if.o_pc), 64'h0);
`endif

      // Reset mid-operation overrides a simultaneous trap
      rst_n = 1'b0; trap_v = 1'b1; trap_vec = 32'h80;
      step();
      trap_v = 1'b0;
      check_all("midreset", 32'h1000, 1'b0, 1'b1, 1'b0);
      rst_n = 1'b1;
      step();
      check_all("midreset.run", 32'h1000, 1'b1, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
